// File: rtl/sockit_cdc_pkg.sv
// ---------------------------------------------------------------------------
// sockit_cdc_pkg
// Shared definitions for the sockit_cdc traffic source (ffi side) and the
// future traffic checker (ffo side).
//   src_state_t : source FSM state encoding (IDLE / RUN / DONE)
//   LFSR_MASK   : Galois tap mask for x^32+x^22+x^2+x+1
//   lfsr_step   : one step of the 32-bit Galois LFSR (pure function)
// ---------------------------------------------------------------------------
package sockit_cdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } src_state_t;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   // Right-shifting Galois form: the bit shifted out of bit 0 is folded back
   // through the tap mask. A non-zero state never reaches zero.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/sockit_cdc_src_if.sv
// ---------------------------------------------------------------------------
// sockit_cdc_src_if
// Valid/ready stream carrying DW-bit words into the ffi (write) port of
// sockit_cdc.
//   bus : data word          (master -> slave)
//   vld : data valid         (master -> slave)
//   rdy : sink ready         (slave  -> master)
// A word transfers on a clock edge where vld and rdy are both high.
// ---------------------------------------------------------------------------
interface sockit_cdc_src_if #(
   parameter int DW = 8
);
   logic [DW-1:0] bus;
   logic          vld;
   logic          rdy;

   modport master (
      output bus,
      output vld,
      input  rdy
   );

   modport slave (
      input  bus,
      input  vld,
      output rdy
   );
endinterface

// File: rtl/sockit_cdc_src.sv
// ---------------------------------------------------------------------------
// sockit_cdc_src
// Programmable stream transmitter for the ffi side of sockit_cdc. After a
// start pulse it sends cfg_len incrementing words beginning at cfg_ini; the
// rate at which valid is offered is throttled by a 32-bit LFSR compared
// against cfg_prb.
//
// Ports
//   ffi_clk  in   clock
//   ffi_rst  in   asynchronous active-high reset
//   cmd_str  in   start pulse, sampled only in IDLE
//   cmd_abt  in   abort request, level-sensitive in RUN
//   cfg_len  in   beats to send (sampled on start)
//   cfg_ini  in   first data value (sampled on start)
//   cfg_prb  in   valid probability threshold (sampled on start)
//   sts_bsy  out  high in RUN and DONE
//   sts_dne  out  one-cycle completion pulse (the DONE cycle)
//   sts_cnt  out  beats transferred in the current/last run
//   ffi      if   stream master (bus, vld out; rdy in)
// All outputs are registered.
// ---------------------------------------------------------------------------
module sockit_cdc_src
   import sockit_cdc_pkg::*;
#(
   parameter int          DW   = 8,
   parameter int          CW   = 16,
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic                    ffi_clk,
   input  logic                    ffi_rst,
   input  logic                    cmd_str,
   input  logic                    cmd_abt,
   input  logic [CW-1:0]           cfg_len,
   input  logic [DW-1:0]           cfg_ini,
   input  logic [31:0]             cfg_prb,
   output logic                    sts_bsy,
   output logic                    sts_dne,
   output logic [CW-1:0]           sts_cnt,
   sockit_cdc_src_if.master        ffi
);

   // A zero seed would lock the LFSR at zero forever.
   localparam logic [31:0] SEED_I = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

   src_state_t    state_r, state_nx;

   logic          vld_r,  vld_nx;
   logic [DW-1:0] dat_r,  dat_nx;
   logic [CW-1:0] cnt_r,  cnt_nx;
   logic          bsy_r,  bsy_nx;
   logic          dne_r,  dne_nx;
   logic [31:0]   lfsr_r, lfsr_nx;
   logic          abt_r,  abt_nx;

   // run configuration, captured on start; never observed before a start
   logic [CW-1:0] len_r,  len_nx;
   logic [31:0]   prb_r,  prb_nx;

   logic          trn;
   logic          dec;
   logic          abt_now;
   logic [CW-1:0] cnt_trn;
   logic          more;
   logic [31:0]   lfsr_adv;

   assign trn      = vld_r & ffi.rdy;
   // A decision point is any RUN edge where no beat is pending afterwards
   // unless a new one is offered.
   assign dec      = (state_r == ST_RUN) & (~vld_r | trn);
   // The latched abort only matters once the pending beat has gone.
   assign abt_now  = abt_r | cmd_abt;
   assign cnt_trn  = cnt_r + CW'(trn);
   assign more     = (cnt_trn < len_r);
   assign lfsr_adv = lfsr_step(lfsr_r);

   // ---- state register -----------------------------------------------------
   always_ff @(posedge ffi_clk or posedge ffi_rst) begin
      if (ffi_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // ---- next-state logic ---------------------------------------------------
   always_comb begin
      state_nx = state_r;
      unique case (state_r)
         ST_IDLE: begin
            if (cmd_str) begin
               state_nx = (cfg_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Leave only when nothing is pending and either all beats have
            // gone or an abort is in force. An LFSR stall keeps us in RUN.
            if (dec && (!more || abt_now)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // ---- output / datapath next values --------------------------------------
   always_comb begin
      vld_nx  = vld_r;
      dat_nx  = dat_r;
      cnt_nx  = cnt_r;
      lfsr_nx = lfsr_r;
      abt_nx  = abt_r;
      len_nx  = len_r;
      prb_nx  = prb_r;

      unique case (state_r)
         ST_IDLE: begin
            if (cmd_str) begin
               len_nx = cfg_len;
               prb_nx = cfg_prb;
               dat_nx = cfg_ini;
               cnt_nx = '0;
               abt_nx = 1'b0;
            end
         end
         ST_RUN: begin
            if (cmd_abt) begin
               abt_nx = 1'b1;
            end
            if (trn) begin
               dat_nx = dat_r + DW'(1);
               cnt_nx = cnt_trn;
            end
            if (dec) begin
               lfsr_nx = lfsr_adv;
               vld_nx  = more & ~abt_now & (lfsr_adv <= prb_r);
            end
         end
         default: begin
         end
      endcase

      bsy_nx = (state_nx != ST_IDLE);
      dne_nx = (state_nx == ST_DONE);
   end

   // ---- control / output registers -----------------------------------------
   always_ff @(posedge ffi_clk or posedge ffi_rst) begin
      if (ffi_rst) begin
         vld_r  <= 1'b0;
         dat_r  <= '0;
         cnt_r  <= '0;
         bsy_r  <= 1'b0;
         dne_r  <= 1'b0;
         lfsr_r <= SEED_I;
         abt_r  <= 1'b0;
      end else begin
         vld_r  <= vld_nx;
         dat_r  <= dat_nx;
         cnt_r  <= cnt_nx;
         bsy_r  <= bsy_nx;
         dne_r  <= dne_nx;
         lfsr_r <= lfsr_nx;
         abt_r  <= abt_nx;
      end
   end

   // ---- captured configuration ---------------------------------------------
   always_ff @(posedge ffi_clk) begin
      len_r <= len_nx;
      prb_r <= prb_nx;
   end

   assign ffi.vld = vld_r;
   assign ffi.bus = dat_r;
   assign sts_bsy = bsy_r;
   assign sts_dne = dne_r;
   assign sts_cnt = cnt_r;

endmodule

// File: tb/tb_sockit_cdc_src.sv
// ---------------------------------------------------------------------------
// tb_sockit_cdc_src
// Directed bench for sockit_cdc_src: full rate with data wrap, backpressure,
// zero length, stall with abort, abort with a pending beat, random ready,
// and reset in mid-run followed by a deterministic rerun.
// ---------------------------------------------------------------------------
module tb_sockit_cdc_src;

   localparam int DW = 8;
   localparam int CW = 16;

   logic          ffi_clk = 1'b0;
   logic          ffi_rst = 1'b1;
   logic          cmd_str = 1'b0;
   logic          cmd_abt = 1'b0;
   logic [CW-1:0] cfg_len = '0;
   logic [DW-1:0] cfg_ini = '0;
   logic [31:0]   cfg_prb = '0;
   logic          sts_bsy;
   logic          sts_dne;
   logic [CW-1:0] sts_cnt;

   sockit_cdc_src_if #(.DW(DW)) ffi_if ();

   sockit_cdc_src #(.DW(DW), .CW(CW), .SEED(32'h0000_0001)) dut (
      .ffi_clk (ffi_clk),
      .ffi_rst (ffi_rst),
      .cmd_str (cmd_str),
      .cmd_abt (cmd_abt),
      .cfg_len (cfg_len),
      .cfg_ini (cfg_ini),
      .cfg_prb (cfg_prb),
      .sts_bsy (sts_bsy),
      .sts_dne (sts_dne),
      .sts_cnt (sts_cnt),
      .ffi     (ffi_if)
   );

   always #5 ffi_clk = ~ffi_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ffi_clk);
      #1;
   endtask

   task automatic start(input logic [CW-1:0] len, input logic [DW-1:0] ini, input logic [31:0] prb);
      cfg_len = len;
      cfg_ini = ini;
      cfg_prb = prb;
      cmd_str = 1'b1;
      tick();
      cmd_str = 1'b0;
   endtask

   // Runs len=8 from 8'h10 at prb=7FFFFFFF with rdy=1, recording vld per cycle.
   task automatic run_pat(input string tag, output logic [255:0] pat, output int ncyc);
      int nbeat;
      pat   = '0;
      ncyc  = 0;
      nbeat = 0;
      ffi_if.rdy = 1'b1;
      start(16'd8, 8'h10, 32'h7FFF_FFFF);
      for (int c = 0; c < 256; c++) begin
         if (sts_dne) break;
         pat[c] = ffi_if.vld;
         if (ffi_if.vld) begin
            chk({tag, "_data"}, 32'(ffi_if.bus), 32'((16 + nbeat) & 255));
            nbeat++;
         end
         ncyc++;
         tick();
      end
      chk({tag, "_dne"}, 32'(sts_dne), 32'd1);
      chk({tag, "_cnt"}, 32'(sts_cnt), 32'd8);
      tick();
   endtask

   logic [255:0] pat_a, pat_b;
   int           ncyc_a, ncyc_b;

   initial begin
      int beats;
      int seen;
      logic          hold;
      logic [DW-1:0] hold_bus;

      ffi_if.rdy = 1'b0;

      // ---- reset values
      tick();
      tick();
      chk("rst_vld", 32'(ffi_if.vld), 32'd0);
      chk("rst_bus", 32'(ffi_if.bus), 32'd0);
      chk("rst_bsy", 32'(sts_bsy), 32'd0);
      chk("rst_dne", 32'(sts_dne), 32'd0);
      chk("rst_cnt", 32'(sts_cnt), 32'd0);
      ffi_rst = 1'b0;
      tick();

      // ---- fresh run from SEED (reference pattern)
      run_pat("fresh", pat_a, ncyc_a);

      // ---- full rate, data wraps F8..FF,00..07
      ffi_if.rdy = 1'b1;
      start(16'd16, 8'hF8, 32'hFFFF_FFFF);
      chk("full_e0_vld", 32'(ffi_if.vld), 32'd0);
      chk("full_e0_bsy", 32'(sts_bsy), 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("full_vld", 32'(ffi_if.vld), 32'd1);
         chk("full_bus", 32'(ffi_if.bus), 32'((248 + i) & 255));
      end
      tick();
      chk("full_end_vld", 32'(ffi_if.vld), 32'd0);
      chk("full_dne", 32'(sts_dne), 32'd1);
      chk("full_cnt", 32'(sts_cnt), 32'd16);
      chk("full_dne_bsy", 32'(sts_bsy), 32'd1);
      tick();
      chk("full_idle_dne", 32'(sts_dne), 32'd0);
      chk("full_idle_bsy", 32'(sts_bsy), 32'd0);

      // ---- backpressure, with a start pulse during RUN that must be ignored
      ffi_if.rdy = 1'b0;
      start(16'd4, 8'hA5, 32'hFFFF_FFFF);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_vld", 32'(ffi_if.vld), 32'd1);
         chk("bp_hold_bus", 32'(ffi_if.bus), 32'hA5);
         if (i == 4) begin
            cfg_ini = 8'h00;
            cfg_len = 16'd50;
            cmd_str = 1'b1;
         end
         tick();
         cmd_str = 1'b0;
      end
      ffi_if.rdy = 1'b1;
      beats = 0;
      for (int c = 0; c < 50; c++) begin
         if (sts_dne) break;
         if (ffi_if.vld) begin
            chk("bp_bus", 32'(ffi_if.bus), 32'((165 + beats) & 255));
            beats++;
         end
         tick();
      end
      chk("bp_dne", 32'(sts_dne), 32'd1);
      chk("bp_beats", 32'(beats), 32'd4);
      chk("bp_cnt", 32'(sts_cnt), 32'd4);
      tick();

      // ---- zero length
      start(16'd0, 8'h33, 32'hFFFF_FFFF);
      chk("zero_dne", 32'(sts_dne), 32'd1);
      chk("zero_bsy", 32'(sts_bsy), 32'd1);
      chk("zero_vld", 32'(ffi_if.vld), 32'd0);
      chk("zero_cnt", 32'(sts_cnt), 32'd0);
      tick();
      chk("zero_idle_dne", 32'(sts_dne), 32'd0);
      chk("zero_idle_bsy", 32'(sts_bsy), 32'd0);
      chk("zero_idle_vld", 32'(ffi_if.vld), 32'd0);

      // ---- prb=0 stalls until aborted
      start(16'd4, 8'h00, 32'h0000_0000);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ffi_if.vld) seen++;
      end
      chk("stall_novld", 32'(seen), 32'd0);
      chk("stall_bsy", 32'(sts_bsy), 32'd1);
      cmd_abt = 1'b1;
      tick();
      cmd_abt = 1'b0;
      chk("stall_abt_dne", 32'(sts_dne), 32'd1);
      chk("stall_abt_cnt", 32'(sts_cnt), 32'd0);
      tick();

      // ---- abort with a pending beat
      ffi_if.rdy = 1'b0;
      start(16'd10, 8'h40, 32'hFFFF_FFFF);
      tick();
      tick();
      tick();
      cmd_abt = 1'b1;
      tick();
      cmd_abt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abt_hold_vld", 32'(ffi_if.vld), 32'd1);
         chk("abt_hold_bus", 32'(ffi_if.bus), 32'h40);
         tick();
      end
      ffi_if.rdy = 1'b1;
      tick();
      chk("abt_vld_drop", 32'(ffi_if.vld), 32'd0);
      chk("abt_dne", 32'(sts_dne), 32'd1);
      chk("abt_cnt", 32'(sts_cnt), 32'd1);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ffi_if.vld) seen++;
      end
      chk("abt_no_more", 32'(seen), 32'd0);
      chk("abt_idle_bsy", 32'(sts_bsy), 32'd0);

      // ---- random ready, 256 beats in order, handshake stability
      start(16'd256, 8'h00, 32'h7FFF_FFFF);
      beats = 0;
      hold  = 1'b0;
      hold_bus = '0;
      for (int c = 0; c < 4000; c++) begin
         if (hold) begin
            chk("rnd_stable_vld", 32'(ffi_if.vld), 32'd1);
            chk("rnd_stable_bus", 32'(ffi_if.bus), 32'(hold_bus));
         end
         if (sts_dne) break;
         ffi_if.rdy = 1'($urandom_range(0, 1));
         if (ffi_if.vld && ffi_if.rdy) begin
            chk("rnd_data", 32'(ffi_if.bus), 32'(beats & 255));
            beats++;
         end
         hold     = ffi_if.vld && !ffi_if.rdy;
         hold_bus = ffi_if.bus;
         tick();
      end
      chk("rnd_dne", 32'(sts_dne), 32'd1);
      chk("rnd_beats", 32'(beats), 32'd256);
      chk("rnd_cnt", 32'(sts_cnt), 32'd256);
      tick();

      // ---- reset after 5 beats, then rerun must match the fresh pattern
      ffi_if.rdy = 1'b1;
      start(16'd20, 8'h10, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) tick();
      chk("mid_cnt_pre", 32'(sts_cnt), 32'd5);
      ffi_rst = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(ffi_if.vld), 32'd0);
      chk("mid_rst_bus", 32'(ffi_if.bus), 32'd0);
      chk("mid_rst_bsy", 32'(sts_bsy), 32'd0);
      chk("mid_rst_cnt", 32'(sts_cnt), 32'd0);
      chk("mid_rst_dne", 32'(sts_dne), 32'd0);
      tick();
      tick();
      ffi_rst = 1'b0;
      tick();
      run_pat("rerun", pat_b, ncyc_b);
      chk("rerun_ncyc", 32'(ncyc_b), 32'(ncyc_a));
      for (int w = 0; w < 8; w++) begin
         chk("rerun_pat", pat_b[w*32 +: 32], pat_a[w*32 +: 32]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
